calc_alu_seq: RTL

Parametrised, clocked successor to the 8-bit add/subtract calculator. Holds two operand registers loaded from a shared data bus and executes one of eight operations on START. Single-cycle logic and add/subtract operations complete in one cycle; unsigned multiply is a WIDTH-cycle shift-add sequence. Registered result, high product word and condition codes {V,C,N,Z} feed the display/flag logic downstream.

---
 rtl/calc_alu_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/calc_alu_seq.sv
// Clocked calculator: two operand registers, eight ops, shift-add unsigned multiply.
// Optional macro CALC_SAT_EN makes ADD/SUB saturate in signed arithmetic.
module calc_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] rh,
  output logic [3:0]       cc,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   a_r, b_r, r_r, rh_r;
  logic [3:0]         cc_r;
  logic               busy_r, done_r;
  logic [2*WIDTH-1:0] mcand_r, acc_r, acc_nxt_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               mul_last_s;
  logic [WIDTH-1:0]   b_op_s, alu_res_s;
  logic [WIDTH:0]     sum_s;
  logic               carry_s, ovf_s, alu_c_s, alu_v_s;
  logic [3:0]         alu_cc_s, mul_cc_s;

  function automatic logic [3:0] pack_cc(input logic v, input logic c, input logic [WIDTH-1:0] res);
    pack_cc = {v, c, res[WIDTH-1], (res == {WIDTH{1'b0}})};
  endfunction

  // Single-cycle ALU on the pre-edge register contents
  always_comb begin
    b_op_s    = (op == OP_SUB) ? ~b_r : b_r;
    sum_s     = {1'b0, a_r} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    carry_s   = sum_s[WIDTH];
    ovf_s     = a_r[WIDTH-1] ^ b_op_s[WIDTH-1] ^ sum_s[WIDTH-1] ^ carry_s;
    alu_res_s = r_r;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
`ifdef CALC_SAT_EN
        // Overflow sign follows A: both ADD and SUB(A + ~B) overflow only when the addend signs match
        alu_res_s = ovf_s ? (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                          : sum_s[WIDTH-1:0];
`else
        alu_res_s = sum_s[WIDTH-1:0];
`endif
        alu_c_s = carry_s;
        alu_v_s = ovf_s;
      end
      OP_AND:  alu_res_s = a_r & b_r;
      OP_OR:   alu_res_s = a_r | b_r;
      OP_XOR:  alu_res_s = a_r ^ b_r;
      OP_PASS: alu_res_s = a_r;
      default: alu_res_s = r_r;
    endcase
    alu_cc_s = pack_cc(alu_v_s, alu_c_s, alu_res_s);
  end

  // One shift-add step of the multiply
  always_comb begin
    acc_nxt_s  = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    mul_last_s = (cnt_r == CW'(WIDTH - 1));
    mul_cc_s   = {(acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}), 1'b0,
                  acc_nxt_s[WIDTH-1], (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}})};
  end

  // FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (op == OP_MUL)) state_nxt_s = ST_MUL;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_last_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_MUL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand, result, flag and multiply datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      rh_r     <= {WIDTH{1'b0}};
      cc_r     <= 4'b0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (ld_a) a_r <= d;
      if (ld_b) b_r <= d;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_r  <= {{WIDTH{1'b0}}, a_r};
              mplier_r <= b_r;
              acc_r    <= {(2*WIDTH){1'b0}};
              cnt_r    <= {CW{1'b0}};
              busy_r   <= 1'b1;
            end else begin
              done_r <= 1'b1;
              if (op != OP_NOP) begin
                r_r  <= alu_res_s;
                rh_r <= {WIDTH{1'b0}};
                cc_r <= alu_cc_s;
              end
            end
          end
        end
        ST_MUL: begin
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          acc_r    <= acc_nxt_s;
          cnt_r    <= cnt_r + CW'(1);
          if (mul_last_s) begin
            r_r    <= acc_nxt_s[WIDTH-1:0];
            rh_r   <= acc_nxt_s[2*WIDTH-1:WIDTH];
            cc_r   <= mul_cc_s;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign a_q  = a_r;
  assign b_q  = b_r;
  assign r    = r_r;
  assign rh   = rh_r;
  assign cc   = cc_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
